// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC source and drives IF/ID, ID/EX stall/flush, HALT and a stall counter.
// Controls are combinational from state and inputs; an EX redirect seen while frozen is parked in PEND.
module pc_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dmem_busy,
  input  logic             lduse_haz,
  input  logic             branch_ex,
  input  logic             beq_ex,
  input  logic             zero_ex,
  input  logic             jr_ex,
  input  logic             jump_id,
  input  logic             halt_mem,
  output logic             pcenable,
  output logic [1:0]       pcsrc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

  state_t     state, state_nx;
  logic [1:0] pend_src, pend_nx;
  logic       taken, redir_ex, freeze;

  assign taken    = branch_ex & (beq_ex ? zero_ex : ~zero_ex);
  assign redir_ex = taken | jr_ex;
  assign freeze   = dmem_busy | ~ihit;
  assign halted   = (state == HALT);

  always_comb begin
    state_nx   = state;
    pend_nx    = pend_src;
    pcenable   = 1'b0;
    pcsrc      = 2'b00;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state)
      RUN: begin
        if (halt_mem) begin
          state_nx   = HALT;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (redir_ex) begin
          pcsrc = jr_ex ? 2'b11 : 2'b01;
          if (!freeze) begin
            pcenable   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else begin
            stall_ifid = 1'b1;
            pend_nx    = jr_ex ? 2'b11 : 2'b01;
            state_nx   = PEND;
          end
        end else if (lduse_haz) begin
          // hazard beats an ID jump; the jump re-presents once the bubble is in
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (jump_id && !freeze) begin
          pcenable   = 1'b1;
          pcsrc      = 2'b10;
          flush_ifid = 1'b1;
        end else begin
          pcenable   = ihit & ~dmem_busy;
          stall_ifid = freeze;
        end
      end
      PEND: begin
        pcsrc = pend_src;
        if (halt_mem) begin
          state_nx   = HALT;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (freeze) begin
          stall_ifid = 1'b1;
        end else begin
          pcenable   = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_nx   = RUN;
        end
      end
      HALT: begin
        stall_ifid = 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      pend_src  <= 2'b00;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      pend_src <= pend_nx;
      if (!pcenable && state != HALT)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; inputs change 1ns after the rising edge, outputs are checked on the falling edge.
module tb_pc_sequencer;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dmem_busy, lduse_haz, branch_ex, beq_ex, zero_ex, jr_ex, jump_id, halt_mem;
  logic       pcenable, stall_ifid, flush_ifid, flush_idex, halted;
  logic [1:0] pcsrc;
  logic [3:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_busy(dmem_busy), .lduse_haz(lduse_haz),
    .branch_ex(branch_ex), .beq_ex(beq_ex), .zero_ex(zero_ex), .jr_ex(jr_ex),
    .jump_id(jump_id), .halt_mem(halt_mem), .pcenable(pcenable), .pcsrc(pcsrc),
    .stall_ifid(stall_ifid), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pe, input logic [1:0] src,
                         input logic st, input logic fi, input logic fe);
    chk({tag, ".pcenable"},   32'(pcenable),   32'(pe));
    chk({tag, ".pcsrc"},      32'(pcsrc),      32'(src));
    chk({tag, ".stall_ifid"}, 32'(stall_ifid), 32'(st));
    chk({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(fi));
    chk({tag, ".flush_idex"}, 32'(flush_idex), 32'(fe));
  endtask

  // argument order: ihit, dmem_busy, lduse_haz, branch_ex, beq_ex, zero_ex, jr_ex, jump_id, halt_mem
  task automatic drv(input logic ih, input logic db, input logic lu, input logic br,
                     input logic bq, input logic zr, input logic jr, input logic jp, input logic hm);
    ihit = ih; dmem_busy = db; lduse_haz = lu; branch_ex = br; beq_ex = bq;
    zero_ex = zr; jr_ex = jr; jump_id = jp; halt_mem = hm;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    drv(0,0,0,0,0,0,0,0,0);
    tick; tick;
    @(negedge CLK);
    chk_out("reset", 0, 2'b00, 1, 0, 0);
    chk("reset.halted", 32'(halted), 0);
    chk("reset.cnt", 32'(stall_cnt), 0);

    tick;
    nRST = 1'b1;
    drv(1,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk_out($sformatf("seq%0d", i), 1, 2'b00, 0, 0, 0);
      tick;
    end
    chk("seq.cnt", 32'(stall_cnt), 0);

    drv(1,0,0,1,1,1,0,0,0); @(negedge CLK); chk_out("beq_taken", 1, 2'b01, 0, 1, 1); tick;
    drv(1,0,0,1,1,0,0,0,0); @(negedge CLK); chk_out("beq_not",   1, 2'b00, 0, 0, 0); tick;
    drv(1,0,0,1,0,0,0,0,0); @(negedge CLK); chk_out("bne_taken", 1, 2'b01, 0, 1, 1); tick;
    drv(1,0,0,1,0,1,0,0,0); @(negedge CLK); chk_out("bne_not",   1, 2'b00, 0, 0, 0); tick;

    // JR while fetch stalls; jr_ex drops during PEND to show the source is held
    drv(0,0,0,0,0,0,1,0,0); @(negedge CLK); chk_out("jr_frz0", 0, 2'b11, 1, 0, 0); tick;
    drv(0,0,0,0,0,0,0,0,0); @(negedge CLK); chk_out("jr_frz1", 0, 2'b11, 1, 0, 0); tick;
    drv(0,0,0,0,0,0,0,0,0); @(negedge CLK); chk_out("jr_frz2", 0, 2'b11, 1, 0, 0); tick;
    drv(1,0,0,0,0,0,0,0,0); @(negedge CLK); chk_out("jr_go",   1, 2'b11, 0, 1, 1); tick;
    drv(1,0,0,0,0,0,0,0,0); @(negedge CLK); chk_out("jr_after", 1, 2'b00, 0, 0, 0);
    chk("jr.cnt", 32'(stall_cnt), 3); tick;

    drv(1,0,1,0,0,0,0,1,0); @(negedge CLK); chk_out("lduse_jmp", 0, 2'b00, 1, 0, 1); tick;
    drv(1,0,0,0,0,0,0,1,0); @(negedge CLK); chk_out("jmp",       1, 2'b10, 0, 1, 0);
    chk("jmp.cnt", 32'(stall_cnt), 4); tick;
    drv(1,0,1,1,1,1,0,1,0); @(negedge CLK); chk_out("redir_wins", 1, 2'b01, 0, 1, 1); tick;
    drv(1,1,0,0,0,0,0,1,0); @(negedge CLK); chk_out("jmp_busy",   0, 2'b00, 1, 0, 0); tick;

    drv(1,0,0,1,1,1,0,0,1); @(negedge CLK); chk_out("halt_entry", 0, 2'b00, 0, 1, 1);
    chk("halt_entry.cnt", 32'(stall_cnt), 5);
    chk("halt_entry.halted", 32'(halted), 0); tick;
    for (int i = 0; i < 10; i++) begin
      drv(1'(i), 1'(i>>1), 1'(i>>2), 1, 1'(i), 0, 1'(i>>1), 1, 1'(i>>2));
      @(negedge CLK);
      chk($sformatf("halt%0d.halted", i), 32'(halted), 1);
      chk_out($sformatf("halt%0d", i), 0, 2'b00, 1, 0, 0);
      chk($sformatf("halt%0d.cnt", i), 32'(stall_cnt), 6);
      tick;
    end

    nRST = 1'b0; drv(0,0,0,0,0,0,0,0,0); tick;
    nRST = 1'b1; drv(1,1,0,0,0,0,1,0,0);
    @(negedge CLK); chk("unhalt.halted", 32'(halted), 0); chk("unhalt.cnt", 32'(stall_cnt), 0);
    chk_out("pend_in", 0, 2'b11, 1, 0, 0); tick;
    drv(1,1,0,0,0,0,0,0,0); @(negedge CLK); chk_out("pend_hold", 0, 2'b11, 1, 0, 0);
    nRST = 1'b0; tick;
    nRST = 1'b1; drv(1,0,0,0,0,0,0,0,0);
    @(negedge CLK);
    chk_out("pend_reset", 1, 2'b00, 0, 0, 0);
    chk("pend_reset.halted", 32'(halted), 0);
    chk("pend_reset.cnt", 32'(stall_cnt), 0); tick;

    drv(0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 15; i++) tick;
    @(negedge CLK); chk("wrap15", 32'(stall_cnt), 15); tick;
    drv(1,0,0,0,0,0,0,0,0);
    @(negedge CLK); chk("wrap16", 32'(stall_cnt), 0); tick;
    @(negedge CLK); chk("wrap_hold", 32'(stall_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
